off_chip_img_stream_ctrl: RTL and testbench

- Upstream feeder for the sobel accelerator's off_chip_img input port.
- Issues sequential word reads to an external memory port for one IMG_W x IMG_H frame, starting at BASE_ADDR.
- Buffers responses in a credit-limited prefetch FIFO.
- Presents the FIFO head on the accelerator's off_chip_img_img_update_0_read lane and pops one entry per read_en.

---
 rtl/off_chip_img_stream_ctrl_if.sv | 33 +++
 rtl/off_chip_img_stream_ctrl.sv | 144 ++++++++++++++
 tb/tb_off_chip_img_stream_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/off_chip_img_stream_ctrl_if.sv
// Memory request/response channel and the accelerator read lane
// between off_chip_img_stream_ctrl and its neighbours.
interface off_chip_img_stream_ctrl_if #(
  parameter int AW = 16
);
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid;
  logic [15:0]   mem_rsp_data;
  logic          off_chip_img_img_update_0_read_en;
  logic [15:0]   off_chip_img_img_update_0_read [0:0];

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    output off_chip_img_img_update_0_read,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data,
    input  off_chip_img_img_update_0_read_en
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    input  off_chip_img_img_update_0_read,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data,
    output off_chip_img_img_update_0_read_en
  );
endinterface

// File: rtl/off_chip_img_stream_ctrl.sv
// Frame prefetcher: issues sequential word reads for one image, buffers the
// responses in a credit-limited FIFO and serves them on the sobel read lane.
module off_chip_img_stream_ctrl #(
  parameter int          IMG_W      = 64,
  parameter int          IMG_H      = 64,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          FIFO_DEPTH = 8,
  parameter int          AW         = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  off_chip_img_stream_ctrl_if.master  bus,
  output logic                        frame_done,
  output logic                        underflow
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int OW    = $clog2(FIFO_DEPTH + 1);
  localparam int PW    = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] TOTAL_C  = CW'(TOTAL);
  localparam logic [OW:0]   DEPTH_C  = (OW + 1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] BASE_C   = AW'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_DRAIN  = 3'd2,
    S_DONE   = 3'd3,
    S_ABORT  = 3'd4
  } state_t;

  state_t          state_r, state_next_s;
  logic [CW-1:0]   req_cnt_r, pop_cnt_r, req_cnt_next_s, pop_cnt_next_s;
  logic [OW-1:0]   outstanding_r, outstanding_next_s;
  logic [OW-1:0]   count_r, count_after_pop_s;
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r, rd_ptr_next_s;
  logic [15:0]     fifo_mem_r [FIFO_DEPTH];
  logic [15:0]     lane_r, lane_next_s;
  logic            underflow_r, frame_done_r;
  logic            active_s, credit_ok_s, req_valid_s, hs_s, rsp_s;
  logic            push_s, pop_s, clear_s;

  // Datapath strobes and next-state decode.
  always_comb begin
    state_next_s       = state_r;
    active_s           = (state_r == S_STREAM) || (state_r == S_DRAIN);
    credit_ok_s        = (({1'b0, count_r} + {1'b0, outstanding_r}) < DEPTH_C);
    req_valid_s        = (state_r == S_STREAM) && (req_cnt_r < TOTAL_C) && credit_ok_s;
    hs_s               = req_valid_s && bus.mem_req_ready;
    // Responses with nothing outstanding are left over from before a reset.
    rsp_s              = bus.mem_rsp_valid && (outstanding_r != {OW{1'b0}});
    push_s             = rsp_s && active_s;
    pop_s              = bus.off_chip_img_img_update_0_read_en && (count_r != {OW{1'b0}}) && active_s;
    clear_s            = flush && (state_r != S_ABORT);
    outstanding_next_s = outstanding_r + OW'(hs_s) - OW'(rsp_s);
    req_cnt_next_s     = req_cnt_r + CW'(hs_s);
    pop_cnt_next_s     = pop_cnt_r + CW'(pop_s);
    rd_ptr_next_s      = rd_ptr_r + PW'(pop_s);
    count_after_pop_s  = count_r - OW'(pop_s);

    case (state_r)
      S_IDLE, S_DONE: begin
        if (flush) state_next_s = S_STREAM;
        else       state_next_s = state_r;
      end
      S_STREAM: begin
        if (flush)                           state_next_s = (outstanding_next_s == {OW{1'b0}}) ? S_STREAM : S_ABORT;
        else if (req_cnt_next_s == TOTAL_C)  state_next_s = S_DRAIN;
        else                                 state_next_s = state_r;
      end
      S_DRAIN: begin
        if (flush)                           state_next_s = (outstanding_next_s == {OW{1'b0}}) ? S_STREAM : S_ABORT;
        else if (pop_cnt_next_s == TOTAL_C)  state_next_s = S_DONE;
        else                                 state_next_s = state_r;
      end
      S_ABORT: begin
        if (outstanding_next_s == {OW{1'b0}}) state_next_s = S_STREAM;
        else                                  state_next_s = state_r;
      end
      default: state_next_s = S_IDLE;
    endcase

    // No bypass: the lane only ever reflects what is stored after this edge.
    if (clear_s)                              lane_next_s = lane_r;
    else if (count_after_pop_s != {OW{1'b0}}) lane_next_s = fifo_mem_r[rd_ptr_next_s];
    else if (push_s)                          lane_next_s = bus.mem_rsp_data;
    else                                      lane_next_s = lane_r;
  end

  // Control state, counters and sticky status.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r       <= S_IDLE;
      req_cnt_r     <= {CW{1'b0}};
      pop_cnt_r     <= {CW{1'b0}};
      outstanding_r <= {OW{1'b0}};
      count_r       <= {OW{1'b0}};
      wr_ptr_r      <= {PW{1'b0}};
      rd_ptr_r      <= {PW{1'b0}};
      lane_r        <= 16'h0000;
      underflow_r   <= 1'b0;
      frame_done_r  <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      outstanding_r <= outstanding_next_s;
      lane_r        <= lane_next_s;
      frame_done_r  <= (state_next_s == S_DONE);
      if (clear_s) begin
        req_cnt_r   <= {CW{1'b0}};
        pop_cnt_r   <= {CW{1'b0}};
        count_r     <= {OW{1'b0}};
        wr_ptr_r    <= {PW{1'b0}};
        rd_ptr_r    <= {PW{1'b0}};
        underflow_r <= 1'b0;
      end else begin
        req_cnt_r   <= req_cnt_next_s;
        pop_cnt_r   <= pop_cnt_next_s;
        count_r     <= count_after_pop_s + OW'(push_s);
        wr_ptr_r    <= wr_ptr_r + PW'(push_s);
        rd_ptr_r    <= rd_ptr_next_s;
        if (bus.off_chip_img_img_update_0_read_en && (count_r == {OW{1'b0}}) && active_s)
          underflow_r <= 1'b1;
        else
          underflow_r <= underflow_r;
      end
    end
  end

  // Prefetch storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s && !clear_s) fifo_mem_r[wr_ptr_r] <= bus.mem_rsp_data;
    else                    fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
  end

  assign bus.mem_req_valid                     = req_valid_s;
  assign bus.mem_req_addr                      = BASE_C + AW'(req_cnt_r);
  assign bus.off_chip_img_img_update_0_read[0] = lane_r;
  assign frame_done                            = frame_done_r;
  assign underflow                             = underflow_r;

endmodule

// File: tb/tb_off_chip_img_stream_ctrl.sv
// Scoreboard bench for off_chip_img_stream_ctrl: 4x2 frame at 0x10, 4-deep FIFO,
// memory model answering with data = address after a programmable latency.
module tb_off_chip_img_stream_ctrl;

  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  logic frame_done, underflow;

  off_chip_img_stream_ctrl_if #(.AW(AW)) bus ();

  off_chip_img_stream_ctrl #(
    .IMG_W(4), .IMG_H(2), .BASE_ADDR(32'h10), .FIFO_DEPTH(4), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.master),
    .frame_done(frame_done), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] addr; int due; } pend_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_addr [$];
  logic [15:0] exp_data [$];
  pend_t       pend [$];
  int          occ = 0;
  int          inflight = 0;
  bit          aborting = 1'b0;
  int          hs_total = 0;
  int          cons_mode = 0;
  int          lat = 1;
  int          cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
  endtask

  task automatic push_frame();
    logic [15:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 16'h0010 + 16'(i);
      exp_addr.push_back(v);
      exp_data.push_back(v);
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while (!frame_done && k < budget) begin step(1); k++; end
    check({name, "_frame_done"}, {31'd0, frame_done}, 32'd1);
    check({name, "_addr_left"}, exp_addr.size(), 32'd0);
    check({name, "_data_left"}, exp_data.size(), 32'd0);
  endtask

  // Memory responder and consumer driver.
  initial begin
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 16'h0000;
    bus.off_chip_img_img_update_0_read_en = 1'b0;
    forever begin
      logic        hs;
      logic [15:0] a;
      @(negedge clk);
      hs = bus.mem_req_valid && bus.mem_req_ready;
      a  = bus.mem_req_addr;
      if (rst_n) pend.delete();
      else if (hs) pend.push_back('{a, cyc + lat});
      @(posedge clk); #2;
      cyc++;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = pend[0].addr;
        void'(pend.pop_front());
      end else begin
        bus.mem_rsp_valid = 1'b0;
      end
      case (cons_mode)
        1: bus.off_chip_img_img_update_0_read_en = 1'b1;
        2: bus.off_chip_img_img_update_0_read_en = (occ > 0);
        3: begin
          bus.off_chip_img_img_update_0_read_en = (occ > 0);
          if (occ > 0) cons_mode = 0;
        end
        4: bus.off_chip_img_img_update_0_read_en = (occ > 0) && ($urandom_range(0, 1) == 1);
        default: bus.off_chip_img_img_update_0_read_en = 1'b0;
      endcase
    end
  end

  // Monitor: compares request addresses and popped lane values against the queues.
  initial begin
    forever begin
      int hs_i, rsp_i, pop_i, inf_n;
      @(posedge clk); #3;
      if (rst_n) begin
        occ = 0; inflight = 0; aborting = 1'b0;
      end else begin
        hs_i  = (bus.mem_req_valid && bus.mem_req_ready) ? 1 : 0;
        rsp_i = bus.mem_rsp_valid ? 1 : 0;
        pop_i = (bus.off_chip_img_img_update_0_read_en && occ > 0 && !aborting) ? 1 : 0;
        if (hs_i == 1) begin
          hs_total++;
          if (exp_addr.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL req_addr: got 0x%0h, expected no request", bus.mem_req_addr);
          end else check("req_addr", {16'd0, bus.mem_req_addr}, {16'd0, exp_addr.pop_front()});
        end
        if (pop_i == 1) begin
          if (exp_data.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL lane_data: got 0x%0h, expected no pop", bus.off_chip_img_img_update_0_read[0]);
          end else check("lane_data", {16'd0, bus.off_chip_img_img_update_0_read[0]}, {16'd0, exp_data.pop_front()});
        end
        inf_n = inflight + hs_i - rsp_i;
        if (flush && !aborting) begin
          occ = 0;
          aborting = (inf_n != 0);
        end else if (aborting) begin
          occ = 0;
          if (inf_n == 0) aborting = 1'b0;
        end else begin
          occ = occ + rsp_i - pop_i;
        end
        inflight = inf_n;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.mem_req_ready = 1'b0;
    step(3);
    check("rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    check("rst_req_addr", {16'd0, bus.mem_req_addr}, 32'h10);
    check("rst_lane", {16'd0, bus.off_chip_img_img_update_0_read[0]}, 32'h0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_underflow", {31'd0, underflow}, 32'd0);
    rst_n = 1'b0;
    step(2);
    check("idle_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);

    // Basic frame with a consumer that only reads valid data.
    bus.mem_req_ready = 1'b1; lat = 1; cons_mode = 2;
    push_frame();
    pulse_flush();
    wait_done(100, "basic");
    check("basic_underflow", {31'd0, underflow}, 32'd0);
    cons_mode = 1;
    step(3);
    check("done_underflow", {31'd0, underflow}, 32'd0);
    check("done_lane_hold", {16'd0, bus.off_chip_img_img_update_0_read[0]}, 32'h17);
    check("done_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);

    // Credit limit with the consumer idle, then a single pop.
    cons_mode = 0;
    push_frame();
    hs_total = 0;
    pulse_flush();
    step(12);
    check("credit_reqs", hs_total, 32'd4);
    check("credit_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    cons_mode = 3;
    step(8);
    check("credit_reqs_after_pop", hs_total, 32'd5);
    check("credit_valid_after_pop", {31'd0, bus.mem_req_valid}, 32'd0);
    cons_mode = 2;
    wait_done(100, "credit");

    // Memory stall: the request must hold steady.
    bus.mem_req_ready = 1'b0;
    push_frame();
    pulse_flush();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, bus.mem_req_valid}, 32'd1);
      check("stall_addr", {16'd0, bus.mem_req_addr}, 32'h10);
      step(1);
    end
    bus.mem_req_ready = 1'b1;
    wait_done(100, "stall");

    // Underflow: read_en high from the cycle after flush.
    cons_mode = 1;
    push_frame();
    pulse_flush();
    step(2);
    check("uf_set", {31'd0, underflow}, 32'd1);
    wait_done(100, "uf");
    step(3);
    check("uf_sticky", {31'd0, underflow}, 32'd1);

    // Flush with three reads in flight.
    cons_mode = 0; lat = 8; bus.mem_req_ready = 1'b0;
    pulse_flush();
    check("flush_clears_uf", {31'd0, underflow}, 32'd0);
    hs_total = 0;
    exp_addr.push_back(16'h0010);
    exp_addr.push_back(16'h0011);
    exp_addr.push_back(16'h0012);
    bus.mem_req_ready = 1'b1;
    step(3);
    bus.mem_req_ready = 1'b0;
    check("abort_inflight", hs_total, 32'd3);
    push_frame();
    pulse_flush();
    check("abort_no_req", {31'd0, bus.mem_req_valid}, 32'd0);
    bus.mem_req_ready = 1'b1; cons_mode = 2;
    step(2);
    check("abort_no_req_hold", {31'd0, bus.mem_req_valid}, 32'd0);
    wait_done(300, "abort");

    // Random stalls on both sides across several frames.
    lat = 1;
    k = 0;
    while (k < 100) begin
      push_frame();
      pulse_flush();
      cons_mode = 4;
      for (int j = 0; j < 300; j++) begin
        bus.mem_req_ready = ($urandom_range(0, 1) == 1);
        step(1);
        k++;
        if (frame_done) break;
      end
      wait_done(1, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
